// File: rtl/booth_pkg.sv
// Shared command codes and FSM state encoding for the sequential Booth multiplier.
package booth_pkg;

    localparam logic [2:0] CMD_NOP     = 3'b000;
    localparam logic [2:0] CMD_INIT    = 3'b001;
    localparam logic [2:0] CMD_LOAD_M  = 3'b011;
    localparam logic [2:0] CMD_LOAD_Q  = 3'b010;
    localparam logic [2:0] CMD_START   = 3'b100;
    localparam logic [2:0] CMD_READ_HI = 3'b101;
    localparam logic [2:0] CMD_READ_LO = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/booth_mult_seq_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M', then an
// arithmetic right shift of {A, Q', q_1}. All operands are N+1 bits wide.
module booth_step #(
    parameter int N = 8
) (
    input  logic [N:0] a_i,
    input  logic [N:0] q_i,
    input  logic       q1_i,
    input  logic [N:0] m_i,
    output logic [N:0] a_o,
    output logic [N:0] q_o,
    output logic       q1_o
);

    logic [N:0] sum_s;

    // Booth recoding of the current bit pair, then the combined shift
    always_comb begin
        sum_s = a_i;
        case ({q_i[0], q1_i})
            2'b01:   sum_s = a_i + m_i;
            2'b10:   sum_s = a_i - m_i;
            default: sum_s = a_i;
        endcase
        a_o  = {sum_s[N], sum_s[N:1]};
        q_o  = {sum_s[0], q_i[N:1]};
        q1_o = q_i[0];
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier behind a 3-bit command bus; operands are
// widened by one bit so signed and unsigned products come out exact.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       enable,
    input  logic [WIDTH-1:0] inbus,
    input  logic             signed_en,
    output logic [WIDTH-1:0] outbus,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     m_q, m_d, q_q, q_d, out_q, out_d;
    logic [WIDTH:0]       mp_q, mp_d, a_q, a_d, qp_q, qp_d;
    logic                 q1_q, q1_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH:0]       a_nxt_s, qp_nxt_s;
    logic                 q1_nxt_s;
    logic                 busy_s, done_s;

    function automatic logic [WIDTH:0] ext(input logic [WIDTH-1:0] v, input logic s);
        return {s & v[WIDTH-1], v};
    endfunction

    booth_step #(.N(WIDTH)) u_step (
        .a_i  (a_q),
        .q_i  (qp_q),
        .q1_i (q1_q),
        .m_i  (mp_q),
        .a_o  (a_nxt_s),
        .q_o  (qp_nxt_s),
        .q1_o (q1_nxt_s)
    );

    // State and datapath registers; reset overrides every command
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            q_q     <= '0;
            mp_q    <= '0;
            a_q     <= '0;
            qp_q    <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            q_q     <= q_d;
            mp_q    <= mp_d;
            a_q     <= a_d;
            qp_q    <= qp_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            out_q   <= out_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable == CMD_START) state_d = ST_RUN;
                else                     state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (enable == CMD_INIT)    state_d = ST_IDLE;
                else if (cnt_q == CNT_ONE) state_d = ST_DONE;
                else                       state_d = ST_RUN;
            end
            ST_DONE: begin
                if (enable == CMD_START) state_d = ST_RUN;
                else if (enable == CMD_INIT || enable == CMD_LOAD_M || enable == CMD_LOAD_Q)
                    state_d = ST_IDLE;
                else
                    state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath updates; while running only INIT is honoured
    always_comb begin
        m_d    = m_q;
        q_d    = q_q;
        mp_d   = mp_q;
        a_d    = a_q;
        qp_d   = qp_q;
        q1_d   = q1_q;
        cnt_d  = cnt_q;
        prod_d = prod_q;
        out_d  = out_q;
        if (state_q == ST_RUN) begin
            if (enable == CMD_INIT) begin
                m_d    = '0;
                q_d    = '0;
                prod_d = '0;
                cnt_d  = '0;
            end else begin
                a_d   = a_nxt_s;
                qp_d  = qp_nxt_s;
                q1_d  = q1_nxt_s;
                cnt_d = cnt_q - CNT_ONE;
                // Product fits in 2W bits, so the top two bits of {A,Q'} are dropped
                if (cnt_q == CNT_ONE) prod_d = {a_nxt_s[WIDTH-2:0], qp_nxt_s};
                else                  prod_d = prod_q;
            end
        end else begin
            case (enable)
                CMD_INIT: begin
                    m_d    = '0;
                    q_d    = '0;
                    prod_d = '0;
                end
                CMD_LOAD_M:  m_d = inbus;
                CMD_LOAD_Q:  q_d = inbus;
                CMD_START: begin
                    a_d   = '0;
                    qp_d  = ext(q_q, signed_en);
                    mp_d  = ext(m_q, signed_en);
                    q1_d  = 1'b0;
                    cnt_d = CNT_LOAD;
                end
                CMD_READ_HI: out_d = prod_q[2*WIDTH-1:WIDTH];
                CMD_READ_LO: out_d = prod_q[WIDTH-1:0];
                default: begin
                end
            endcase
        end
    end

    // Status outputs decoded from the state register
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_q)
            ST_RUN:  busy_s = 1'b1;
            ST_DONE: done_s = 1'b1;
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    assign outbus = out_q;
    assign busy   = busy_s;
    assign done   = done_s;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq: a command-level model of the 8-bit unit is
// compared every cycle, with literal products checked for W=8 and W=16.
module tb_booth_mult_seq;
    import booth_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  en8, en16;
    logic [7:0]  in8, out8;
    logic [15:0] in16, out16;
    logic        sg8, sg16, busy8, busy16, done8, done16;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    booth_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .enable(en8), .inbus(in8), .signed_en(sg8),
        .outbus(out8), .busy(busy8), .done(done8)
    );

    booth_mult_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .enable(en16), .inbus(in16), .signed_en(sg16),
        .outbus(out16), .busy(busy16), .done(done16)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mul8(input logic [7:0] m, input logic [7:0] q, input logic s);
        logic signed [15:0] ms, qs;
        if (s) begin
            ms = 16'($signed(m));
            qs = 16'($signed(q));
            return 16'(ms * qs);
        end
        return 16'({8'h00, m} * {8'h00, q});
    endfunction

    // Command-level model of the 8-bit instance
    logic [7:0]  mdl_m, mdl_q, mdl_out;
    logic [15:0] mdl_prod, mdl_pend;
    logic        mdl_busy, mdl_done;
    int          mdl_cnt;

    always @(posedge clk) begin
        if (rst) begin
            mdl_m <= 8'h00; mdl_q <= 8'h00; mdl_out <= 8'h00;
            mdl_prod <= 16'h0000; mdl_pend <= 16'h0000;
            mdl_busy <= 1'b0; mdl_done <= 1'b0; mdl_cnt <= 0;
        end else if (mdl_busy) begin
            if (en8 == CMD_INIT) begin
                mdl_busy <= 1'b0; mdl_done <= 1'b0; mdl_prod <= 16'h0000;
                mdl_m <= 8'h00; mdl_q <= 8'h00;
            end else begin
                if (mdl_cnt == 1) begin
                    mdl_busy <= 1'b0; mdl_done <= 1'b1; mdl_prod <= mdl_pend;
                end
                mdl_cnt <= mdl_cnt - 1;
            end
        end else begin
            case (en8)
                CMD_INIT:    begin mdl_m <= 8'h00; mdl_q <= 8'h00; mdl_prod <= 16'h0000; mdl_done <= 1'b0; end
                CMD_LOAD_M:  begin mdl_m <= in8; mdl_done <= 1'b0; end
                CMD_LOAD_Q:  begin mdl_q <= in8; mdl_done <= 1'b0; end
                CMD_START:   begin
                    mdl_busy <= 1'b1; mdl_done <= 1'b0; mdl_cnt <= 9;
                    mdl_pend <= mul8(mdl_m, mdl_q, sg8);
                end
                CMD_READ_HI: mdl_out <= mdl_prod[15:8];
                CMD_READ_LO: mdl_out <= mdl_prod[7:0];
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_outbus", {24'h0, out8}, {24'h0, mdl_out});
            check("model_busy",   {31'h0, busy8}, {31'h0, mdl_busy});
            check("model_done",   {31'h0, done8}, {31'h0, mdl_done});
        end
    end

    task automatic cmd8(input logic [2:0] c, input logic [7:0] d);
        en8 = c; in8 = d;
        @(negedge clk);
        en8 = CMD_NOP;
    endtask

    task automatic cmd16(input logic [2:0] c, input logic [15:0] d);
        en16 = c; in16 = d;
        @(negedge clk);
        en16 = CMD_NOP;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done8(output int lat);
        lat = 0;
        while (!done8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_done16(output int lat);
        lat = 0;
        while (!done16 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run8(input logic [7:0] m, input logic [7:0] q, input logic s, output int lat);
        cmd8(CMD_LOAD_M, m);
        cmd8(CMD_LOAD_Q, q);
        sg8 = s;
        cmd8(CMD_START, 8'h00);
        wait_done8(lat);
    endtask

    task automatic read8(output logic [15:0] p);
        cmd8(CMD_READ_HI, 8'h00);
        p[15:8] = out8;
        cmd8(CMD_READ_LO, 8'h00);
        p[7:0] = out8;
    endtask

    initial begin
        int lat;
        logic [15:0] p;
        logic [15:0] hi16, lo16;

        rst = 1'b1; en8 = CMD_NOP; en16 = CMD_NOP;
        in8 = 8'h00; in16 = 16'h0000; sg8 = 1'b0; sg16 = 1'b0;
        idle(2);
        check("reset_outbus", {24'h0, out8}, 32'h0);
        check("reset_busy",   {31'h0, busy8}, 32'h0);
        check("reset_done",   {31'h0, done8}, 32'h0);
        rst = 1'b0;
        chk_en = 1'b1;

        cmd8(CMD_READ_LO, 8'h00);
        check("read_before_product", {24'h0, out8}, 32'h0);

        cmd8(CMD_INIT, 8'h00);
        run8(8'h11, 8'h03, 1'b0, lat);
        check("latency_w8", lat, 32'd9);
        read8(p);
        check("u_11x03", {16'h0, p}, 32'h0033);

        run8(8'hFD, 8'h05, 1'b1, lat);
        read8(p);
        check("s_m3x5", {16'h0, p}, 32'hFFF1);

        run8(8'h80, 8'h80, 1'b1, lat);
        read8(p);
        check("s_min_x_min", {16'h0, p}, 32'h4000);

        run8(8'hFF, 8'hFF, 1'b0, lat);
        read8(p);
        check("u_ff_x_ff", {16'h0, p}, 32'hFE01);

        // Back-to-back START from DONE with the same operands, now signed
        sg8 = 1'b1;
        cmd8(CMD_START, 8'h00);
        check("done_drops_on_start", {31'h0, done8}, 32'h0);
        wait_done8(lat);
        check("latency_b2b", lat, 32'd9);
        read8(p);
        check("s_m1_x_m1", {16'h0, p}, 32'h0001);

        // Commands other than INIT are ignored while running
        sg8 = 1'b0;
        cmd8(CMD_LOAD_M, 8'h11);
        cmd8(CMD_LOAD_Q, 8'h03);
        cmd8(CMD_START, 8'h00);
        idle(2);
        cmd8(CMD_LOAD_M, 8'h22);
        cmd8(CMD_START, 8'h00);
        cmd8(CMD_READ_HI, 8'h00);
        check("outbus_held_in_run", {24'h0, out8}, 32'h01);
        wait_done8(lat);
        check("latency_ignored", lat + 5, 32'd9);
        read8(p);
        check("ignored_result", {16'h0, p}, 32'h0033);

        // Abort with INIT on the fourth RUN clock
        cmd8(CMD_START, 8'h00);
        idle(3);
        cmd8(CMD_INIT, 8'h00);
        check("abort_busy", {31'h0, busy8}, 32'h0);
        check("abort_done", {31'h0, done8}, 32'h0);
        cmd8(CMD_READ_LO, 8'h00);
        check("abort_read_lo", {24'h0, out8}, 32'h0);

        // Synchronous reset in the middle of RUN
        run8(8'h11, 8'h03, 1'b0, lat);
        cmd8(CMD_READ_LO, 8'h00);
        check("pre_reset_read", {24'h0, out8}, 32'h33);
        cmd8(CMD_START, 8'h00);
        idle(3);
        rst = 1'b1;
        @(negedge clk);
        check("midrun_rst_outbus", {24'h0, out8}, 32'h0);
        check("midrun_rst_busy",   {31'h0, busy8}, 32'h0);
        check("midrun_rst_done",   {31'h0, done8}, 32'h0);
        rst = 1'b0;

        // Wider instance
        cmd16(CMD_LOAD_M, 16'h1234);
        cmd16(CMD_LOAD_Q, 16'h0010);
        sg16 = 1'b0;
        cmd16(CMD_START, 16'h0000);
        wait_done16(lat);
        check("latency_w16", lat, 32'd17);
        cmd16(CMD_READ_HI, 16'h0000);
        hi16 = out16;
        cmd16(CMD_READ_LO, 16'h0000);
        lo16 = out16;
        check("w16_hi", {16'h0, hi16}, 32'h0001);
        check("w16_lo", {16'h0, lo16}, 32'h2340);

        cmd16(CMD_LOAD_M, 16'h8000);
        cmd16(CMD_LOAD_Q, 16'h8000);
        sg16 = 1'b1;
        cmd16(CMD_START, 16'h0000);
        wait_done16(lat);
        cmd16(CMD_READ_HI, 16'h0000);
        hi16 = out16;
        cmd16(CMD_READ_LO, 16'h0000);
        lo16 = out16;
        check("w16_s_min_sq", {hi16, lo16}, 32'h4000_0000);

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
